// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with a load/store request/response handshake.
// Word-spanning accesses are split over two edges by a small FSM, or rejected.
module dmem_lsu #(
    parameter int MEM_DEPTH      = 1024,
    parameter int MISALIGN_SPLIT = 1,
    parameter int ADDR_W         = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int WORDS = MEM_DEPTH / 4;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state;

    logic [31:0] mem [WORDS];

    logic [1:0]      off;
    logic [WA_W-1:0] w0;
    logic [WA_W-1:0] w1;
    logic [3:0]      size_mask;
    logic [7:0]      lane_span;
    logic [3:0]      m0;
    logic [3:0]      m1;
    logic            spans;
    logic            bad;
    logic [63:0]     wide;

    logic            lat_we;
    logic            lat_unsigned;
    logic [1:0]      lat_size;
    logic [1:0]      lat_off;
    logic [WA_W-1:0] lat_w1;
    logic [3:0]      lat_mask;
    logic [31:0]     lat_wdata;
    logic [31:0]     hold;

    logic            wr_en;
    logic [WA_W-1:0] wr_addr;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_data;

    // Bytes touched form a lane mask over an 8-byte window; lanes 7:4 belong to the next word.
    always_comb begin
        off = req_addr[1:0];
        w0  = req_addr[ADDR_W-1:2];
        w1  = w0 + 1'b1;
        case (req_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        lane_span = {4'b0000, size_mask} << off;
        m0        = lane_span[3:0];
        m1        = lane_span[7:4];
        spans     = |m1;
        bad       = (req_size == 2'b11) || (spans && (MISALIGN_SPLIT == 0));
        wide      = {32'h0, req_wdata} << {off, 3'b000};
    end

    function automatic logic [31:0] funnel(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] sh);
        return 32'({hi, lo} >> {sh, 3'b000});
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // One word write per edge: the accepted request's first word, or the latched second word.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = w0;
        wr_mask = m0;
        wr_data = wide[31:0];
        if (!rst) begin
            if (state == IDLE) begin
                wr_en = req_valid && req_we && !bad;
            end else begin
                wr_en   = lat_we;
                wr_addr = lat_w1;
                wr_mask = lat_mask;
                wr_data = lat_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Control FSM; the response registers double as the synchronous read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_off      <= 2'b00;
            lat_w1       <= '0;
            lat_mask     <= 4'b0000;
            lat_wdata    <= 32'h0;
            hold         <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (spans) begin
                            state        <= SPLIT;
                            req_ready    <= 1'b0;
                            lat_we       <= req_we;
                            lat_unsigned <= req_unsigned;
                            lat_size     <= req_size;
                            lat_off      <= off;
                            lat_w1       <= w1;
                            lat_mask     <= m1;
                            lat_wdata    <= wide[63:32];
                            hold         <= mem[w0];
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= req_we ? 32'h0
                                        : extend(funnel(32'h0, mem[w0], off), req_size, req_unsigned);
                        end
                    end
                end
                SPLIT: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= lat_we ? 32'h0
                                : extend(funnel(mem[lat_w1], hold, lat_off), lat_size, lat_unsigned);
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a byte-level memory model predicts every response of a
// splitting instance and a rejecting instance; directed vectors carry literals.
module tb_dmem_lsu;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              req_valid_s   [2];
    logic              req_ready_s   [2];
    logic              req_we_s      [2];
    logic [ADDR_W-1:0] req_addr_s    [2];
    logic [1:0]        req_size_s    [2];
    logic              req_unsigned_s[2];
    logic [31:0]       req_wdata_s   [2];
    logic              resp_valid_s  [2];
    logic [31:0]       resp_rdata_s  [2];
    logic              resp_err_s    [2];

    dmem_lsu #(.MEM_DEPTH(MEM_DEPTH), .MISALIGN_SPLIT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
        .req_addr(req_addr_s[0]), .req_size(req_size_s[0]), .req_unsigned(req_unsigned_s[0]),
        .req_wdata(req_wdata_s[0]), .resp_valid(resp_valid_s[0]), .resp_rdata(resp_rdata_s[0]),
        .resp_err(resp_err_s[0])
    );

    dmem_lsu #(.MEM_DEPTH(MEM_DEPTH), .MISALIGN_SPLIT(0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
        .req_addr(req_addr_s[1]), .req_size(req_size_s[1]), .req_unsigned(req_unsigned_s[1]),
        .req_wdata(req_wdata_s[1]), .resp_valid(resp_valid_s[1]), .resp_rdata(resp_rdata_s[1]),
        .resp_err(resp_err_s[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          has_lit;
        logic [31:0] lit_rdata;
        logic        lit_err;
        string       name;
    } exp_t;

    typedef struct {
        int         inst;
        int         edge_n;
        int         addr;
        logic [7:0] val;
    } pend_t;

    exp_t       exp_q[$];
    pend_t      pend_q[$];
    logic [7:0] mm [2][MEM_DEPTH];
    int         busy [2];
    int         edge_cnt = 0;
    int         errors   = 0;
    int         checks   = 0;
    bit         mon_en   = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic void flush_pending(input int i);
        for (int k = pend_q.size() - 1; k >= 0; k--) begin
            if (pend_q[k].inst == i && pend_q[k].edge_n <= edge_cnt) begin
                mm[i][pend_q[k].addr] = pend_q[k].val;
                pend_q.delete(k);
            end
        end
    endfunction

    // Access semantics straight from byte addresses: bytes addr..addr+n-1, wrapping the memory.
    function automatic void model_accept(input int i, input bit we, input int addr, input int size,
                                         input bit uns, input logic [31:0] wd, input int acc_edge,
                                         input bit has_lit, input logic [31:0] lit,
                                         input logic lit_err, input string name);
        exp_t        e;
        int          n;
        int          o;
        bit          span;
        logic [31:0] raw;
        flush_pending(i);
        n    = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
        o    = addr % 4;
        span = (n != 0) && (o + n > 4);
        e.inst = i; e.has_lit = has_lit; e.lit_rdata = lit; e.lit_err = lit_err; e.name = name;
        e.due  = acc_edge;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (size == 3 || (span && i == 1)) begin
            e.err = 1'b1;
        end else begin
            if (span) begin
                e.due   = acc_edge + 1;
                busy[i] = acc_edge;
            end
            if (we) begin
                for (int j = 0; j < n; j++) begin
                    if (span && (o + j) >= 4)
                        pend_q.push_back('{i, acc_edge + 1, (addr + j) % MEM_DEPTH, wd[8*j +: 8]});
                    else
                        mm[i][(addr + j) % MEM_DEPTH] = wd[8*j +: 8];
                end
            end else begin
                raw = 32'h0;
                for (int j = 0; j < n; j++) raw[8*j +: 8] = mm[i][(addr + j) % MEM_DEPTH];
                if (!uns && n < 4 && raw[8*n-1])
                    for (int b = n; b < 4; b++) raw[8*b +: 8] = 8'hFF;
                e.rdata = raw;
            end
        end
        exp_q.push_back(e);
    endfunction

    function automatic int find_first(input int i);
        for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].inst == i) return k;
        return -1;
    endfunction

    task automatic compare_inst(input int i);
        int   idx;
        logic have;
        checkOutput($sformatf("ready%0d", i), 32'(req_ready_s[i]), 32'(busy[i] != edge_cnt));
        idx = find_first(i);
        while (idx >= 0 && exp_q[idx].due < edge_cnt) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_missing %s: got no response, required one in cycle %0d",
                     exp_q[idx].name, exp_q[idx].due);
            exp_q.delete(idx);
            idx = find_first(i);
        end
        have = (idx >= 0) && (exp_q[idx].due == edge_cnt);
        checkOutput($sformatf("resp_valid%0d", i), 32'(resp_valid_s[i]), 32'(have));
        if (have) begin
            if (resp_valid_s[i]) begin
                checkOutput({exp_q[idx].name, " rdata"}, resp_rdata_s[i], exp_q[idx].rdata);
                checkOutput({exp_q[idx].name, " err"}, 32'(resp_err_s[i]), 32'(exp_q[idx].err));
                if (exp_q[idx].has_lit) begin
                    checkOutput({exp_q[idx].name, " rdata_lit"}, resp_rdata_s[i], exp_q[idx].lit_rdata);
                    checkOutput({exp_q[idx].name, " err_lit"}, 32'(resp_err_s[i]), 32'(exp_q[idx].lit_err));
                end
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    checkOutput($sformatf("reset_ready%0d", i), 32'(req_ready_s[i]), 32'd1);
                    checkOutput($sformatf("reset_valid%0d", i), 32'(resp_valid_s[i]), 32'd0);
                    checkOutput($sformatf("reset_rdata%0d", i), resp_rdata_s[i], 32'd0);
                    checkOutput($sformatf("reset_err%0d", i), 32'(resp_err_s[i]), 32'd0);
                end else begin
                    compare_inst(i);
                end
            end
        end
    end

    task automatic drive(input int i, input bit v, input bit we, input int addr, input int size,
                         input bit uns, input logic [31:0] wd);
        req_valid_s[i]    = v;
        req_we_s[i]       = we;
        req_addr_s[i]     = addr[ADDR_W-1:0];
        req_size_s[i]     = size[1:0];
        req_unsigned_s[i] = uns;
        req_wdata_s[i]    = wd;
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic applyStimulus(input int i, input bit we, input int addr, input int size,
                                 input bit uns, input logic [31:0] wd, input logic [31:0] lit,
                                 input logic lit_err, input string name);
        int waited = 0;
        drive(i, 1'b1, we, addr, size, uns, wd);
        while (!req_ready_s[i] && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready_s[i]) begin
            checkOutput({name, " accept"}, 32'(req_ready_s[i]), 32'd1);
            idle(i);
            return;
        end
        model_accept(i, we, addr, size, uns, wd, edge_cnt + 1, 1'b1, lit, lit_err, name);
        @(posedge clk); #1;
    endtask

    task automatic store_req(input int i, input int addr, input int size, input logic [31:0] wd,
                             input string name);
        applyStimulus(i, 1'b1, addr, size, 1'b0, wd, 32'h0, 1'b0, name);
    endtask

    task automatic load_req(input int i, input int addr, input int size, input bit uns,
                            input logic [31:0] lit, input string name);
        applyStimulus(i, 1'b0, addr, size, uns, 32'h0, lit, 1'b0, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busy[0] = -1;
        busy[1] = -1;
        for (int i = 0; i < 2; i++) begin
            idle(i);
            for (int a = 0; a < MEM_DEPTH; a++) mm[i][a] = 8'h00;
        end
        #2 rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Preset words whose untouched bytes are read back later.
        store_req(0, 'h14, 2, 32'h0, "pre14");
        store_req(0, 'h18, 2, 32'h0, "pre18");
        store_req(0, 'h00, 2, 32'h0, "pre00");
        store_req(0, 'h3FC, 2, 32'h0, "pre3fc");
        store_req(0, 'h30, 2, 32'h0, "pre30");
        store_req(0, 'h34, 2, 32'h0, "pre34");

        store_req(0, 'h10, 2, 32'hDEADBEEF, "st_w10");
        load_req(0, 'h10, 2, 1'b0, 32'hDEADBEEF, "ld_w10");
        load_req(0, 'h13, 0, 1'b0, 32'hFFFFFFDE, "ld_b13_s");
        load_req(0, 'h13, 0, 1'b1, 32'h000000DE, "ld_b13_u");
        load_req(0, 'h12, 1, 1'b0, 32'hFFFFDEAD, "ld_h12_s");
        idle(0);

        store_req(0, 'h13, 1, 32'h0000A55A, "st_h13_span");
        load_req(0, 'h10, 2, 1'b0, 32'h5AADBEEF, "ld_w10_after");
        load_req(0, 'h14, 2, 1'b0, 32'h000000A5, "ld_w14_after");
        store_req(0, 'h17, 0, 32'hFFFFFF9C, "st_b17");
        store_req(0, 'h18, 0, 32'h000000F1, "st_b18");
        load_req(0, 'h17, 1, 1'b0, 32'hFFFFF19C, "ld_h17_span_s");
        load_req(0, 'h17, 1, 1'b1, 32'h0000F19C, "ld_h17_span_u");
        idle(0);

        store_req(0, MEM_DEPTH - 2, 2, 32'h11223344, "st_w_wrap");
        load_req(0, MEM_DEPTH - 2, 2, 1'b0, 32'h11223344, "ld_w_wrap");
        load_req(0, 'h00, 2, 1'b0, 32'h00001122, "ld_w00_wrap");
        load_req(0, MEM_DEPTH - 4, 2, 1'b0, 32'h33440000, "ld_w3fc_wrap");
        load_req(0, MEM_DEPTH - 1, 1, 1'b1, 32'h00002233, "ld_h3ff_wrap");

        applyStimulus(0, 1'b0, 'h10, 3, 1'b0, 32'h0, 32'h0, 1'b1, "ld_rsvd");
        applyStimulus(0, 1'b1, 'h10, 3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, "st_rsvd");
        load_req(0, 'h10, 2, 1'b0, 32'h5AADBEEF, "ld_w10_rsvd_kept");
        idle(0);

        store_req(1, 'h00, 2, 32'h12345678, "ns_st_w00");
        applyStimulus(1, 1'b0, 'h01, 2, 1'b0, 32'h0, 32'h0, 1'b1, "ns_ld_w01");
        applyStimulus(1, 1'b1, 'h02, 2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, "ns_st_w02");
        applyStimulus(1, 1'b0, 'h03, 1, 1'b0, 32'h0, 32'h0, 1'b1, "ns_ld_h03");
        applyStimulus(1, 1'b0, 'h00, 3, 1'b0, 32'h0, 32'h0, 1'b1, "ns_ld_rsvd");
        load_req(1, 'h00, 2, 1'b0, 32'h12345678, "ns_ld_w00_kept");
        load_req(1, 'h02, 1, 1'b1, 32'h00001234, "ns_ld_h02_u");
        idle(1);

        // Aligned stream with req_valid held high: one response per cycle.
        store_req(0, 'h20, 2, 32'hA0A1A2A3, "s0_st");
        load_req(0, 'h20, 2, 1'b0, 32'hA0A1A2A3, "s1_ld");
        store_req(0, 'h24, 1, 32'h12348001, "s2_st");
        load_req(0, 'h24, 1, 1'b0, 32'hFFFF8001, "s3_ld");
        store_req(0, 'h2A, 0, 32'hFFFFFF7F, "s4_st");
        load_req(0, 'h2A, 0, 1'b0, 32'h0000007F, "s5_ld");
        store_req(0, 'h2C, 2, 32'hCAFEF00D, "s6_st");
        load_req(0, 'h2F, 0, 1'b1, 32'h000000CA, "s7_ld");
        idle(0);

        // Reset lands while the split store is in its second cycle.
        store_req(0, 'h32, 2, 32'hAABBCCDD, "st_split_rst");
        idle(0);
        rst = 1'b1;
        exp_q.delete();
        pend_q.delete();
        busy[0] = -1;
        busy[1] = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        load_req(0, 'h30, 2, 1'b0, 32'hCCDD0000, "ld_w30_post_rst");
        load_req(0, 'h34, 2, 1'b0, 32'h00000000, "ld_w34_post_rst");
        idle(0);

        repeat (5) @(posedge clk);
        #1;
        foreach (exp_q[k]) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_missing %s: got no response, required one in cycle %0d",
                     exp_q[k].name, exp_q[k].due);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
